// File: rtl/fixed_to_float_pipe_pkg.sv
// Shared constants, the IEEE-754 single-precision field layout and sizing helpers
// for the fixed-point to float pipeline.
package fixed_float_pkg;

  localparam int FLOAT_W  = 32;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float_t;

  // Width of a bit-position index into a WIDTH-bit word (never narrower than 1 bit).
  function automatic int pos_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fixed_to_float_pipe_if.sv
// Valid/ready stream interface carrying fixed-point samples in and packed floats out.
interface fixed_to_float_pipe_if #(
  parameter int WIDTH = 23
);

  logic                                in_valid;
  logic                                in_ready;
  logic [WIDTH-1:0]                    in_fixed;
  logic                                out_valid;
  logic                                out_ready;
  logic [fixed_float_pkg::FLOAT_W-1:0] out_float;

  modport master (
    output in_valid, in_fixed, out_ready,
    input  in_ready, out_valid, out_float
  );

  modport slave (
    input  in_valid, in_fixed, out_ready,
    output in_ready, out_valid, out_float
  );

endinterface

// File: rtl/fixed_to_float_pipe_lod.sv
// Combinational leading-one detector: bit position of the highest set bit of mag,
// plus a flag for an all-zero word.
module leading_one_detect
  import fixed_float_pkg::*;
#(
  parameter int WIDTH = 23
) (
  input  logic [WIDTH-1:0]            mag,
  output logic [pos_width(WIDTH)-1:0] pos,
  output logic                        zero
);

  localparam int POS_W = pos_width(WIDTH);

  // NOTE: pos gets a default before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mag[i]) pos = POS_W'(i);
    end
  end

  assign zero = ~|mag;

endmodule

// File: rtl/fixed_to_float_pipe.sv
// Three-stage signed fixed-point to IEEE-754 single converter with a valid/ready
// handshake and a global clock-enable stall; the whole pipeline advances in lockstep.
module fixed_to_float_pipe
  import fixed_float_pkg::*;
#(
  parameter int FRACS = 21,
  parameter int INTS  = 1,
  parameter int WIDTH = INTS + FRACS + 1
) (
  input logic                clk,
  input logic                reset,
  input logic                clk_en,
  fixed_to_float_pipe_if.slave bus
);

  localparam int                POS_W   = pos_width(WIDTH);
  localparam logic [POS_W-1:0]  MSB_POS = POS_W'(WIDTH - 1);
  localparam logic [EXP_W-1:0]  EXP_OFF = EXP_W'(EXP_BIAS - FRACS);

  logic adv;

  // Stage 1: sign / magnitude
  logic             v1;
  logic             s1_sign;
  logic [WIDTH-1:0] s1_mag;
  logic             in_sign;
  logic [WIDTH-1:0] in_mag;

  // Stage 2: leading-one position
  logic             v2;
  logic             s2_sign;
  logic [WIDTH-1:0] s2_mag;
  logic [POS_W-1:0] s2_pos;
  logic             s2_zero;
  logic [POS_W-1:0] lod_pos;
  logic             lod_zero;

  // Stage 3: packed result
  logic             v3;
  float_t           out_q;
  float_t           packed_res;
  logic [POS_W-1:0] shamt;

  // No bubble collapse: every stage moves only when the output slot is free or being drained.
  assign adv           = clk_en && (!v3 || bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3;
  assign bus.out_float = out_q;

  // Two's-complement negate; the most negative input maps onto 2^(WIDTH-1), which still fits unsigned.
  assign in_sign = bus.in_fixed[WIDTH-1];
  assign in_mag  = in_sign ? (~bus.in_fixed + WIDTH'(1)) : bus.in_fixed;

  leading_one_detect #(
    .WIDTH (WIDTH)
  ) u_lod (
    .mag  (s1_mag),
    .pos  (lod_pos),
    .zero (lod_zero)
  );

  // Shifting {mag, 0s} left puts the leading one at the top; the next MANT_W bits are the
  // mantissa and anything lower is truncated (round toward zero).
  assign shamt = MSB_POS - s2_pos;

  always_comb begin
    packed_res = '0;
    if (!s2_zero) begin
      packed_res.sign = s2_sign;
      packed_res.exp  = EXP_OFF + EXP_W'(s2_pos);
      packed_res.mant = MANT_W'(({s2_mag, {MANT_W{1'b0}}} << shamt) >> (WIDTH - 1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages sample the old values on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_mag  <= '0;
      s2_pos  <= '0;
      s2_zero <= 1'b0;
      v3      <= 1'b0;
      out_q   <= '0;
    end else if (adv) begin
      v1      <= bus.in_valid;
      s1_sign <= in_sign;
      s1_mag  <= in_mag;
      v2      <= v1;
      s2_sign <= s1_sign;
      s2_mag  <= s1_mag;
      s2_pos  <= lod_pos;
      s2_zero <= lod_zero;
      v3      <= v2;
      out_q   <= packed_res;
    end
  end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Directed bench for fixed_to_float_pipe at default parameters (WIDTH = 23): hand-computed
// vectors, backpressure, clock-enable stall and asynchronous reset mid-stream.
module tb_fixed_to_float_pipe;

  localparam int W = 23;

  logic clk;
  logic reset;
  logic clk_en;

  int n_asserts;
  int n_fails;

  fixed_to_float_pipe_if #(.WIDTH(W)) bus ();

  fixed_to_float_pipe dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: advance to the rising edge, then settle 1 time unit before checking/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    bus.in_valid = v;
    bus.in_fixed = d;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] f);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    if (v) check({tag, "_float"}, bus.out_float, f);
  endtask

  initial begin
    n_asserts     = 0;
    n_fails       = 0;
    reset         = 1'b0;
    clk_en        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_fixed  = '0;
    bus.out_ready = 1'b1;

    // Reset state: outputs cleared, in_ready tracks clk_en.
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_float", bus.out_float, 32'h0);
    check("rst_in_ready_en1", 32'(bus.in_ready), 32'd1);
    clk_en = 1'b0;
    #1;
    check("rst_in_ready_en0", 32'(bus.in_ready), 32'd0);
    clk_en = 1'b1;
    #1;
    reset = 1'b1;
    tick();

    // Basic values, negatives and zero, one sample per cycle.
    drive(1'b1, 23'h200000); tick(); expect_out("b_lat1", 1'b0, 32'h0);
    drive(1'b1, 23'h100000); tick(); expect_out("b_lat2", 1'b0, 32'h0);
    drive(1'b1, 23'h000001); tick(); expect_out("b_one",  1'b1, 32'h3F800000);
    drive(1'b1, 23'h600000); tick(); expect_out("b_half", 1'b1, 32'h3F000000);
    drive(1'b1, 23'h400000); tick(); expect_out("b_lsb",  1'b1, 32'h35000000);
    drive(1'b1, 23'h000000); tick(); expect_out("b_neg1", 1'b1, 32'hBF800000);
    drive(1'b0, 23'h000000); tick(); expect_out("b_neg2", 1'b1, 32'hC0000000);
    tick();                          expect_out("b_zero", 1'b1, 32'h00000000);
    tick();                          expect_out("b_empty", 1'b0, 32'h0);

    // Backpressure: hold out_ready low for 2 cycles once out_valid rises.
    drive(1'b1, 23'h200000); tick();
    drive(1'b1, 23'h100000); tick();
    drive(1'b1, 23'h600000); tick(); expect_out("bp_s0", 1'b1, 32'h3F800000);
    drive(1'b1, 23'h000001);
    bus.out_ready = 1'b0;
    #1;
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    tick(); expect_out("bp_hold1", 1'b1, 32'h3F800000);
    check("bp_in_ready_hold1", 32'(bus.in_ready), 32'd0);
    tick(); expect_out("bp_hold2", 1'b1, 32'h3F800000);
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    tick(); expect_out("bp_s1", 1'b1, 32'h3F000000);
    drive(1'b0, 23'h000000);
    tick(); expect_out("bp_s2", 1'b1, 32'hBF800000);
    tick(); expect_out("bp_s3", 1'b1, 32'h35000000);
    tick(); expect_out("bp_empty", 1'b0, 32'h0);

    // clk_en low for 3 cycles with the output valid and the consumer ready.
    drive(1'b1, 23'h100000); tick();
    drive(1'b1, 23'h400000); tick();
    drive(1'b1, 23'h000001); tick(); expect_out("ce_s0", 1'b1, 32'h3F000000);
    drive(1'b1, 23'h200000);
    clk_en = 1'b0;
    #1;
    check("ce_in_ready_low", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("ce_freeze%0d", i), 1'b1, 32'h3F000000);
      check($sformatf("ce_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
    end
    clk_en = 1'b1;
    tick(); expect_out("ce_s1", 1'b1, 32'hC0000000);
    drive(1'b0, 23'h000000);
    tick(); expect_out("ce_s2", 1'b1, 32'h35000000);
    tick(); expect_out("ce_s3", 1'b1, 32'h3F800000);
    tick(); expect_out("ce_empty", 1'b0, 32'h0);

    // Asynchronous reset with one result showing and two samples in flight.
    drive(1'b1, 23'h600000); tick();
    drive(1'b1, 23'h100000); tick();
    drive(1'b1, 23'h000001); tick(); expect_out("rs_pre", 1'b1, 32'hBF800000);
    drive(1'b0, 23'h000000);
    #2;
    reset = 1'b0;
    #1;
    check("rs_out_valid", 32'(bus.out_valid), 32'd0);
    check("rs_out_float", bus.out_float, 32'h0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rs_no_stale%0d", i), 32'(bus.out_valid), 32'd0);
    end
    drive(1'b1, 23'h200000); tick(); expect_out("rs_lat1", 1'b0, 32'h0);
    drive(1'b0, 23'h000000); tick(); expect_out("rs_lat2", 1'b0, 32'h0);
    tick(); expect_out("rs_new", 1'b1, 32'h3F800000);
    tick(); expect_out("rs_empty", 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
